eth_rs_10g_link_fault: RTL
==========================

# eth_rs_10g_link_fault

Reconciliation-sublayer link-fault block for 10G Ethernet. It sits between the MAC and `eth_phy_10g` on the 64-bit XGMII in both directions, in a single clock domain.
- **RX:** detects local/remote fault ordered sets in the PHY's received XGMII stream and runs the link-fault state machine. It replaces received data with idles toward the MAC while a fault is active.
- **TX:** substitutes the transmit stream toward the PHY with remote-fault sequences or idles, as the fault state requires.

## Interface
Parameters:
- `DATA_WIDTH` (default 64): XGMII data width; only 64 supported.
- `CTRL_WIDTH` (default `DATA_WIDTH/8`): XGMII control width.
- `FAULT_SEQ_COUNT` (default 4): same-type sequences needed to declare a fault.
- `FAULT_COLUMNS` (default 128): column window / clear timeout.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: the single clock for this block; PHY tx and rx clocks are tied to it.
  - `rst_n` in 1: asynchronous, active-low reset.
- MAC-side XGMII:
  - `mac_xgmii_txd` in 64, `mac_xgmii_txc` in 8: transmit from the MAC.
  - `mac_xgmii_rxd` out 64, `mac_xgmii_rxc` out 8: receive to the MAC.
- PHY-side XGMII:
  - `phy_xgmii_txd` out 64, `phy_xgmii_txc` out 8: transmit to `eth_phy_10g` `xgmii_txd/txc`.
  - `phy_xgmii_rxd` in 64, `phy_xgmii_rxc` in 8: receive from `eth_phy_10g` `xgmii_rxd/rxc`.
- Status and counters:
  - `phy_rx_status` in 1: PHY `rx_status`; low forces local fault.
  - `link_fault` out 2: 00 OK, 01 local fault, 10 remote fault.
  - `fault_event` out 1: one-cycle pulse when `link_fault` changes value.

## Operation
- **Sequence detection:** a word carries a sequence in half h (h=0 lanes 0-3, h=1 lanes 4-7) when all of the following hold:
  - rxc bits of that half equal 0001b.
  - Lane byte 0 is 0x9C.
  - Lane bytes 1-2 are 0x00.
  - Lane byte 3 is 0x01 (local) or 0x02 (remote).
  - Other lane-3 values are ignored.
- **Priority and column counting:** half 0 takes priority, so at most one sequence is counted per word. Columns are counted at 2 per word.
- **State registers:**
  - `seq_type` (2 bits).
  - `seq_cnt` (0..`FAULT_SEQ_COUNT`, 3 bits).
  - `col_cnt` (8 bits, saturates at `FAULT_COLUMNS`).
  - `link_fault`.
- **Sequence word:**
  - If its type differs from `seq_type` or `col_cnt` ≥ `FAULT_COLUMNS`: `seq_type` takes the new type, `seq_cnt`=1, `col_cnt`=0.
  - Otherwise: `seq_cnt`+1, `col_cnt`=0.
  - When `seq_cnt` reaches `FAULT_SEQ_COUNT`: `link_fault`=`seq_type`, and `seq_cnt` holds.
- **Non-sequence word:** `col_cnt`+=2, saturating.
  - If `link_fault`≠OK and `col_cnt` reaches ≥ `FAULT_COLUMNS`: `link_fault`=OK and `seq_cnt`=0.
- **Type change during a fault:** a different-type sequence restarts the count. `link_fault` changes only after `FAULT_SEQ_COUNT` of the new type, or clears via timeout.
- **Forced local fault:** `phy_rx_status`=0 overrides all counting:
  - `link_fault`=01.
  - `seq_cnt`=0, `col_cnt`=0.
  - Normal counting resumes the cycle after status returns high; the fault clears only by the 128-column timeout.
- **RX output:**
  - Pass-through when the updated `link_fault` is OK.
  - Otherwise idle: rxd=0x0707070707070707, rxc=0xFF.
- **TX output:**
  - `link_fault`=OK: MAC pass-through.
  - Local: remote-fault word, txd=0x0200009C0200009C, txc=0x11.
  - Remote: idle word.
- **Frame tracking:** a frame flag is set by /S/ (0xFB with its ctrl bit set) in MAC tx and cleared by /T/ (0xFD).
  - If TX leaves pass-through while the flag is set, the first substituted word is all-/E/: txd=0xFEFE…FE, txc=0xFF.
  - On return to OK mid-frame, pass-through resumes only after the next /T/; idles are sent until then.

## Timing
- **RX path:** 1 register stage. The PHY word sampled at edge N appears on `mac_xgmii_rx*` after edge N, gated by the `link_fault` value updated at the same edge.
- **`link_fault` update:** the 4th qualifying sequence sampled at edge N sets `link_fault` after edge N. `fault_event` pulses in that same cycle.
- **TX path:** 1 register stage, muxed by the registered `link_fault`. TX fault substitution therefore starts 1 cycle after `link_fault` changes.
- **Reset values:**
  - `phy_xgmii_tx*` and `mac_xgmii_rx*`: idle.
  - `link_fault`=00, `fault_event`=0, all counters 0, frame flag 0.
- **Reset mid-operation:** abandons any count or frame immediately; outputs go to idle asynchronously.
- **Window boundary:** a sequence arriving exactly at `col_cnt`=`FAULT_COLUMNS` is outside the window and restarts at 1.

## Test plan
- **Local fault declared:** 4 local sequences (rxd=0x0100009C in lanes 0-3, rxc=0x01), 10 idle words apart.
  - `link_fault`=01 after the 4th.
  - `fault_event` pulses once.
  - phy_txd=0x0200009C0200009C, txc=0x11.
  - MAC rx is idle.
- **Window expiry:** 3 local sequences, then 64 idle words, then 1 local sequence. `link_fault` stays 00 and `seq_cnt`=1.
- **Fault clear:** with `link_fault`=01, 63 idle words keep the fault; the 64th (128 columns) clears it to 00. MAC pass-through resumes on the next TX word.
- **Type switch and remote behaviour:**
  - Alternating local/remote sequences: `link_fault` never sets.
  - Then 4 remote sequences in lane 4 only: `link_fault`=10 and TX sends idles.
- **Mid-frame fault and forced local:**
  - `phy_rx_status` drops while MAC tx is inside a frame: next TX word is 0xFEFE…FE/0xFF, then remote-fault words.
  - `link_fault`=01 in the same cycle as the drop.
  - `rst_n` low mid-frame: all outputs idle immediately.

Source files
------------

// File: rtl/eth_rs_10g_link_fault.sv
// 10G Ethernet reconciliation-sublayer link-fault block.
// RX: detects local/remote fault ordered sets on the PHY XGMII stream, runs the
// link-fault state machine and idles the MAC receive path while a fault is active.
// TX: replaces the MAC transmit stream with remote-fault sequences or idles,
// closing an interrupted frame with an all-/E/ word and waiting for the end of a
// frame before pass-through resumes.
module eth_rs_10g_link_fault #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int FAULT_SEQ_COUNT = 4,
  parameter int FAULT_COLUMNS   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // MAC side
  input  logic [DATA_WIDTH-1:0] mac_xgmii_txd,
  input  logic [CTRL_WIDTH-1:0] mac_xgmii_txc,
  output logic [DATA_WIDTH-1:0] mac_xgmii_rxd,
  output logic [CTRL_WIDTH-1:0] mac_xgmii_rxc,
  // PHY side
  output logic [DATA_WIDTH-1:0] phy_xgmii_txd,
  output logic [CTRL_WIDTH-1:0] phy_xgmii_txc,
  input  logic [DATA_WIDTH-1:0] phy_xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] phy_xgmii_rxc,
  // status
  input  logic                  phy_rx_status,
  output logic [1:0]            link_fault,
  output logic                  fault_event
);

  // link_fault encodings (also the ordered-set type codes carried in lane 3)
  localparam logic [1:0] LF_OK     = 2'b00;
  localparam logic [1:0] LF_LOCAL  = 2'b01;
  localparam logic [1:0] LF_REMOTE = 2'b10;

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam logic [63:0] RF_D   = 64'h0200009C0200009C;
  localparam logic [7:0]  RF_C   = 8'h11;
  localparam logic [63:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [7:0]  ERR_C  = 8'hFF;

  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;

  localparam logic [2:0] FSC = 3'(FAULT_SEQ_COUNT);
  localparam logic [7:0] FC  = 8'(FAULT_COLUMNS);

  // Returns the sequence type carried by one 4-lane column, or 00 if none.
  function automatic logic [1:0] seq_of_half(input logic [31:0] d, input logic [3:0] c);
    logic [1:0] t;
    t = 2'b00;
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[23:8] == 16'h0000 &&
        (d[31:24] == 8'h01 || d[31:24] == 8'h02))
      t = d[25:24];
    return t;
  endfunction

  // ---------------------------------------------------------------- RX side
  logic [1:0] seq_h0, seq_h1, seq_det;
  logic [1:0] seq_type_q, seq_type_d;
  logic [2:0] seq_cnt_q, seq_cnt_d;
  logic [7:0] col_cnt_q, col_cnt_d;
  logic [8:0] col_inc;
  logic [1:0] lf_q, lf_d;

  // Lanes 0-3 win when both halves carry a sequence.
  always_comb begin
    seq_h0  = seq_of_half(phy_xgmii_rxd[31:0],  phy_xgmii_rxc[3:0]);
    seq_h1  = seq_of_half(phy_xgmii_rxd[63:32], phy_xgmii_rxc[7:4]);
    seq_det = (seq_h0 != 2'b00) ? seq_h0 : seq_h1;
  end

  // Link-fault state machine: sequence counting inside the column window,
  // timeout clear, and the forced local fault while the PHY is not ready.
  always_comb begin
    seq_type_d = seq_type_q;
    seq_cnt_d  = seq_cnt_q;
    col_cnt_d  = col_cnt_q;
    lf_d       = lf_q;
    col_inc    = {1'b0, col_cnt_q} + 9'd2;
    if (!phy_rx_status) begin
      lf_d      = LF_LOCAL;
      seq_cnt_d = 3'd0;
      col_cnt_d = 8'd0;
    end else if (seq_det != 2'b00) begin
      // A sequence at col_cnt == FAULT_COLUMNS is already outside the window.
      if (seq_det != seq_type_q || col_cnt_q >= FC) begin
        seq_type_d = seq_det;
        seq_cnt_d  = 3'd1;
      end else if (seq_cnt_q < FSC) begin
        seq_cnt_d = seq_cnt_q + 3'd1;
      end
      col_cnt_d = 8'd0;
      if (seq_cnt_d == FSC)
        lf_d = seq_type_d;
    end else begin
      col_cnt_d = (col_inc >= {1'b0, FC}) ? FC : col_inc[7:0];
      if (lf_q != LF_OK && col_cnt_d >= FC) begin
        lf_d      = LF_OK;
        seq_cnt_d = 3'd0;
      end
    end
  end

  // ---------------------------------------------------------------- TX side
  logic frame_q, frame_d;
  logic tx_pass_q, tx_pass_d;
  logic [DATA_WIDTH-1:0] tx_d;
  logic [CTRL_WIDTH-1:0] tx_c;

  // Frame flag follows /S/ and /T/ in lane order, so the last one in a word wins.
  always_comb begin
    frame_d = frame_q;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (mac_xgmii_txc[i] && mac_xgmii_txd[8*i +: 8] == XG_START)
        frame_d = 1'b1;
      else if (mac_xgmii_txc[i] && mac_xgmii_txd[8*i +: 8] == XG_TERM)
        frame_d = 1'b0;
    end
  end

  // TX mux on the registered fault state. frame_q tells whether the MAC is
  // inside a frame before this word: a frame already partly sent is closed with
  // /E/, and after a fault clears a frame in progress is idled until its /T/.
  always_comb begin
    tx_pass_d = (lf_q == LF_OK) && (tx_pass_q || !frame_q);
    if (tx_pass_d) begin
      tx_d = mac_xgmii_txd;
      tx_c = mac_xgmii_txc;
    end else if (lf_q == LF_OK) begin
      tx_d = IDLE_D;
      tx_c = IDLE_C;
    end else if (tx_pass_q && frame_q) begin
      tx_d = ERR_D;
      tx_c = ERR_C;
    end else if (lf_q == LF_LOCAL) begin
      tx_d = RF_D;
      tx_c = RF_C;
    end else begin
      tx_d = IDLE_D;
      tx_c = IDLE_C;
    end
  end

  // ---------------------------------------------------------------- registers
  // State and output registers; reset drops any count or frame and idles both paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_type_q    <= LF_OK;
      seq_cnt_q     <= 3'd0;
      col_cnt_q     <= 8'd0;
      lf_q          <= LF_OK;
      fault_event   <= 1'b0;
      frame_q       <= 1'b0;
      tx_pass_q     <= 1'b1;
      mac_xgmii_rxd <= IDLE_D;
      mac_xgmii_rxc <= IDLE_C;
      phy_xgmii_txd <= IDLE_D;
      phy_xgmii_txc <= IDLE_C;
    end else begin
      seq_type_q  <= seq_type_d;
      seq_cnt_q   <= seq_cnt_d;
      col_cnt_q   <= col_cnt_d;
      lf_q        <= lf_d;
      fault_event <= (lf_d != lf_q);
      frame_q     <= frame_d;
      tx_pass_q   <= tx_pass_d;
      if (lf_d == LF_OK) begin
        mac_xgmii_rxd <= phy_xgmii_rxd;
        mac_xgmii_rxc <= phy_xgmii_rxc;
      end else begin
        mac_xgmii_rxd <= IDLE_D;
        mac_xgmii_rxc <= IDLE_C;
      end
      phy_xgmii_txd <= tx_d;
      phy_xgmii_txc <= tx_c;
    end
  end

  assign link_fault = lf_q;

endmodule
